dbus_sram_responder: RTL

//   Memory-side responder for the core's data-bus handshake (req valid/addr/size/strobe/data ->

---
 rtl/dbus_sram_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dbus_sram_responder.sv
// -----------------------------------------------------------------------------
// dbus_sram_responder
//   Memory-side responder for the core's data-bus handshake. Backs the bus with a
//   word-addressed 64-bit SRAM and returns a single addr_ok/data_ok pulse a fixed
//   LATENCY cycles after accepting a request. One outstanding request at a time.
//
//   Optional feature macro: DBUS_RESP_STALL_EN
//     When defined, a 16-bit Fibonacci LFSR adds 0..3 random wait cycles to every
//     transaction. When undefined, latency is exactly LATENCY and no LFSR exists.
//
// Parameters
//   DEPTH_LOG2   log2 of SRAM depth in 64-bit words
//   LATENCY      acceptance-to-data_ok cycles, 1..15
//
// Ports
//   clk           clock, all state on posedge
//   reset         synchronous active-high reset (SRAM contents are kept)
//   req_valid     request present, held with req_* until data_ok
//   req_addr      byte address; word index = req_addr[DEPTH_LOG2+2:3]
//   req_size      log2 access bytes, informational only
//   req_strobe    byte write enables, zero = read
//   req_data      lane-aligned write data
//   resp_addr_ok  address accepted pulse (coincides with data_ok)
//   resp_data_ok  transaction complete pulse
//   resp_data     read data, valid while resp_data_ok=1, zero otherwise
// -----------------------------------------------------------------------------
module dbus_sram_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        load_s;
    logic [CNT_W-1:0]        extra_s;
    logic                    accept_s;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [7:0]              strobe_q;
    logic [63:0]             wdata_q;
    logic [63:0]             mem_q [WORDS];
    logic                    resp_addr_ok_q;
    logic                    resp_data_ok_q;
    logic [63:0]             resp_data_q;

    // Size and sub-word / upper address bits do not affect this memory model.
    logic unused_s;
    assign unused_s = ^{req_size, req_addr[63:DEPTH_LOG2+3], req_addr[2:0]};

`ifdef DBUS_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // LFSR next value: taps 16,14,13,11 (bit indices 15,13,12,10).
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register, free-running every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign extra_s = CNT_W'(lfsr_q[1:0]);
`else
    assign extra_s = {CNT_W{1'b0}};
`endif

    assign accept_s = (state_q == ST_IDLE) && req_valid;
    // Number of WAIT cycles for this request; zero goes straight to RESP.
    assign load_s   = LOAD_BASE + extra_s;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (load_s == {CNT_W{1'b0}}) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = load_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 5'd1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch request fields at acceptance so a dropped req_valid still completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= {DEPTH_LOG2{1'b0}};
            strobe_q <= 8'h00;
            wdata_q  <= 64'd0;
        end else if (accept_s) begin
            idx_q    <= req_addr[DEPTH_LOG2+2:3];
            strobe_q <= req_strobe;
            wdata_q  <= req_data;
        end
    end

    // SRAM byte-masked write on the edge leaving RESP; reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ST_RESP)) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Registered response: pulses appear the cycle after RESP, i.e. LATENCY
    // edges after acceptance; that cycle is also the mandatory IDLE bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_addr_ok_q <= 1'b0;
            resp_data_ok_q <= 1'b0;
            resp_data_q    <= 64'd0;
        end else begin
            resp_addr_ok_q <= (state_q == ST_RESP);
            resp_data_ok_q <= (state_q == ST_RESP);
            if ((state_q == ST_RESP) && (strobe_q == 8'h00)) begin
                resp_data_q <= mem_q[idx_q];
            end else begin
                resp_data_q <= 64'd0;
            end
        end
    end

    assign resp_addr_ok = resp_addr_ok_q;
    assign resp_data_ok = resp_data_ok_q;
    assign resp_data    = resp_data_q;

endmodule
